// File: rtl/complex_pkg.sv
// Shared definitions for the complex ALU pipeline: mode encodings and
// width helpers used by the datapath and the round/saturate stage.
package complex_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_MUL  = 2'd2,
    MODE_CMAC = 2'd3
  } cal_mode_e;

  localparam int PIPE_STAGES = 3;

  // Accumulator wide enough that ACC_LEN worst-case conj products never wrap.
  function automatic int acc_width(input int d_width, input int acc_len);
    return 2 * d_width + 1 + $clog2(acc_len);
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  // Half an output LSB at Q1.(w-1) after the product binary point.
  function automatic int rnd_bias(input int w);
    return 1 << (w - 2);
  endfunction

endpackage

// File: rtl/cplx_rnd_sat.sv
// Round-half-up and saturate one wide component to D_WIDTH bits.
// When scale is low the value is only saturated (add/sub path).
module cplx_rnd_sat
  import complex_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int IN_W    = 21
) (
  input  logic signed [IN_W-1:0]    val,
  input  logic                      scale,
  output logic        [D_WIDTH-1:0] res,
  output logic                      ovf
);

  // One guard bit so the rounding bias can never wrap.
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] BIAS = EW'(rnd_bias(D_WIDTH));
  localparam logic signed [EW-1:0] HI   = EW'(sat_hi(D_WIDTH));
  localparam logic signed [EW-1:0] LO   = EW'(sat_lo(D_WIDTH));

  logic signed [EW-1:0] ext, scaled;

  always_comb begin
    ext    = EW'(val);
    scaled = scale ? ((ext + BIAS) >>> (D_WIDTH - 1)) : ext;
    res    = scaled[D_WIDTH-1:0];
    ovf    = 1'b0;
    if (scaled > HI) begin
      res = HI[D_WIDTH-1:0];
      ovf = 1'b1;
    end else if (scaled < LO) begin
      res = LO[D_WIDTH-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/complex_alu_pipe.sv
// Three-stage complex ALU: add/sub/mul and a conj-multiply accumulate over
// ACC_LEN-beat frames, with a single global stall driven by output backpressure.
module complex_alu_pipe
  import complex_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int ACC_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cal_mode,
  input  logic               din_vld,
  output logic               din_rdy,
  input  logic [D_WIDTH-1:0] din_re_1,
  input  logic [D_WIDTH-1:0] din_im_1,
  input  logic [D_WIDTH-1:0] din_re_2,
  input  logic [D_WIDTH-1:0] din_im_2,
  output logic [D_WIDTH-1:0] dout_re,
  output logic [D_WIDTH-1:0] dout_im,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               dout_ovf
);

  localparam int W_ACC = acc_width(D_WIDTH, ACC_LEN);
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  logic                       en, accept;
  logic [PIPE_STAGES:1]       vld_pipe;

  cal_mode_e                  s1_mode;
  logic signed [D_WIDTH-1:0]  s1_re1, s1_im1, s1_re2, s1_im2;
  logic signed [2*D_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [W_ACC-1:0]    t_re, t_im, sum_re, sum_im;
  logic signed [W_ACC-1:0]    acc_re, acc_im, s2_re, s2_im;
  logic                       s2_scale;
  logic [CNT_W-1:0]           cnt;
  logic [D_WIDTH-1:0]         rs_re, rs_im;
  logic                       ovf_re, ovf_im;

  // Whole pipe freezes only when a result is held by the consumer.
  assign en       = !(vld_pipe[PIPE_STAGES] && !dout_rdy);
  assign din_rdy  = en;
  assign accept   = din_vld && din_rdy;
  assign dout_vld = vld_pipe[PIPE_STAGES];

  assign p_rr = s1_re1 * s1_re2;
  assign p_ii = s1_im1 * s1_im2;
  assign p_ri = s1_re1 * s1_im2;
  assign p_ir = s1_im1 * s1_re2;

  always_comb begin
    t_re = '0;
    t_im = '0;
    case (s1_mode)
      MODE_ADD: begin
        t_re = W_ACC'(s1_re1) + W_ACC'(s1_re2);
        t_im = W_ACC'(s1_im1) + W_ACC'(s1_im2);
      end
      MODE_SUB: begin
        t_re = W_ACC'(s1_re1) - W_ACC'(s1_re2);
        t_im = W_ACC'(s1_im1) - W_ACC'(s1_im2);
      end
      MODE_MUL: begin
        t_re = W_ACC'(p_rr) - W_ACC'(p_ii);
        t_im = W_ACC'(p_ri) + W_ACC'(p_ir);
      end
      MODE_CMAC: begin
        t_re = W_ACC'(p_rr) + W_ACC'(p_ii);
        t_im = W_ACC'(p_ir) - W_ACC'(p_ri);
      end
      default: ;
    endcase
    sum_re = acc_re + t_re;
    sum_im = acc_im + t_im;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      cnt      <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      dout_re  <= '0;
      dout_im  <= '0;
      dout_ovf <= 1'b0;
    end else if (en) begin
      vld_pipe[1] <= accept;
      if (accept) begin
        s1_mode <= cal_mode_e'(cal_mode);
        s1_re1  <= din_re_1;
        s1_im1  <= din_im_1;
        s1_re2  <= din_re_2;
        s1_im2  <= din_im_2;
      end

      vld_pipe[2] <= 1'b0;
      if (vld_pipe[1]) begin
        s2_scale <= (s1_mode == MODE_MUL) || (s1_mode == MODE_CMAC);
        if (s1_mode == MODE_CMAC && cnt != LAST) begin
          acc_re <= sum_re;
          acc_im <= sum_im;
          cnt    <= cnt + 1'b1;
        end else begin
          // Frame close or any other mode: emit and restart the frame.
          s2_re       <= (s1_mode == MODE_CMAC) ? sum_re : t_re;
          s2_im       <= (s1_mode == MODE_CMAC) ? sum_im : t_im;
          vld_pipe[2] <= 1'b1;
          acc_re      <= '0;
          acc_im      <= '0;
          cnt         <= '0;
        end
      end

      vld_pipe[3] <= vld_pipe[2];
      dout_ovf    <= vld_pipe[2] && (ovf_re || ovf_im);
      if (vld_pipe[2]) begin
        dout_re <= rs_re;
        dout_im <= rs_im;
      end
    end
  end

  cplx_rnd_sat #(.D_WIDTH(D_WIDTH), .IN_W(W_ACC)) u_rs_re (
    .val(s2_re), .scale(s2_scale), .res(rs_re), .ovf(ovf_re)
  );

  cplx_rnd_sat #(.D_WIDTH(D_WIDTH), .IN_W(W_ACC)) u_rs_im (
    .val(s2_im), .scale(s2_scale), .res(rs_im), .ovf(ovf_im)
  );

endmodule

// File: tb/tb_complex_alu_pipe.sv
// Directed bench for complex_alu_pipe: scoreboard of expected results pushed at
// acceptance and popped as the DUT hands out results.
module tb_complex_alu_pipe;

  localparam int D   = 8;
  localparam int ACC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cal_mode;
  logic         din_vld, din_rdy, dout_vld, dout_rdy, dout_ovf;
  logic [D-1:0] din_re_1, din_im_1, din_re_2, din_im_2, dout_re, dout_im;

  typedef struct {
    logic [D-1:0] re;
    logic [D-1:0] im;
    logic         ovf;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint mre, mim;
  int     mcnt;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  complex_alu_pipe #(.D_WIDTH(D), .ACC_LEN(ACC)) dut (
    .clk(clk), .rst(rst), .cal_mode(cal_mode),
    .din_vld(din_vld), .din_rdy(din_rdy),
    .din_re_1(din_re_1), .din_im_1(din_im_1),
    .din_re_2(din_re_2), .din_im_2(din_im_2),
    .dout_re(dout_re), .dout_im(dout_im),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_ovf(dout_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_res(input longint re, input longint im, input bit scale);
    exp_t e;
    longint hi = (64'sd1 <<< (D - 1)) - 1;
    longint lo = -(64'sd1 <<< (D - 1));
    e.ovf = 1'b0;
    if (scale) begin
      re = (re + (64'sd1 <<< (D - 2))) >>> (D - 1);
      im = (im + (64'sd1 <<< (D - 2))) >>> (D - 1);
    end
    if (re > hi) begin re = hi; e.ovf = 1'b1; end
    if (re < lo) begin re = lo; e.ovf = 1'b1; end
    if (im > hi) begin im = hi; e.ovf = 1'b1; end
    if (im < lo) begin im = lo; e.ovf = 1'b1; end
    e.re = D'(re);
    e.im = D'(im);
    sb.push_back(e);
  endfunction

  task automatic model(input int mode, input logic [D-1:0] r1, i1, r2, i2);
    longint ar = $signed(r1);
    longint ai = $signed(i1);
    longint br = $signed(r2);
    longint bi = $signed(i2);
    if (mode == 3) begin
      mre += ar * br + ai * bi;
      mim += ai * br - ar * bi;
      mcnt++;
      if (mcnt == ACC) begin
        push_res(mre, mim, 1'b1);
        mre = 0; mim = 0; mcnt = 0;
      end
    end else begin
      mre = 0; mim = 0; mcnt = 0;
      case (mode)
        0:       push_res(ar + br, ai + bi, 1'b0);
        1:       push_res(ar - br, ai - bi, 1'b0);
        default: push_res(ar * br - ai * bi, ar * bi + ai * br, 1'b1);
      endcase
    end
  endtask

  // Drive one beat from a falling edge; returns just after the accepting edge.
  task automatic send(input int mode, input logic [D-1:0] r1, i1, r2, i2);
    int w = 0;
    @(negedge clk);
    cal_mode = mode[1:0];
    din_re_1 = r1; din_im_1 = i1; din_re_2 = r2; din_im_2 = i2;
    din_vld  = 1'b1;
    while (!din_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("send_rdy", {31'd0, din_rdy}, 32'd1);
    model(mode, r1, i1, r2, i2);
    @(posedge clk);
    #1 din_vld = 1'b0;
  endtask

  task automatic wait_lat(input string tag, input int exp_lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dout_vld && k < 20);
    chk(tag, k, exp_lat);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && dout_vld === 1'b1 && dout_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {31'd0, dout_vld}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_re", {24'd0, dout_re}, {24'd0, mon_e.re});
        chk("out_im", {24'd0, dout_im}, {24'd0, mon_e.im});
        chk("out_ovf", {31'd0, dout_ovf}, {31'd0, mon_e.ovf});
      end
    end
  end

  initial begin
    logic [2*D:0] snap;
    rst = 1'b1; dout_rdy = 1'b1; din_vld = 1'b0; cal_mode = '0;
    din_re_1 = '0; din_im_1 = '0; din_re_2 = '0; din_im_2 = '0;
    mre = 0; mim = 0; mcnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_re", {24'd0, dout_re}, 32'd0);
    chk("rst_im", {24'd0, dout_im}, 32'd0);
    chk("rst_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_ovf", {31'd0, dout_ovf}, 32'd0);
    chk("rst_rdy", {31'd0, din_rdy}, 32'd1);
    rst = 1'b0;

    // Saturating add, then products with and without saturation.
    send(0, 8'h70, 8'h10, 8'h20, 8'h05);
    wait_lat("lat_add", 3);
    send(2, 8'h40, 8'h00, 8'h40, 8'h00);
    wait_lat("lat_mul", 3);
    send(2, 8'h80, 8'h00, 8'h80, 8'h00);
    wait_lat("lat_mul_sat", 3);
    drain();

    // Mixed back-to-back traffic across modes 0..2.
    for (int i = 0; i < 10; i++)
      send(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    drain();

    // Full accumulate frame: nothing until the fourth beat.
    for (int i = 0; i < 3; i++) send(3, 8'h20, 8'h00, 8'h40, 8'h00);
    repeat (4) begin
      @(negedge clk);
      chk("cmac_early", {31'd0, dout_vld}, 32'd0);
    end
    send(3, 8'h20, 8'h00, 8'h40, 8'h00);
    wait_lat("lat_cmac", 3);
    drain();

    // Abort a partial frame with a mode-0 beat, then a clean frame.
    send(3, 8'h7F, 8'h7F, 8'h7F, 8'h81);
    send(3, 8'h7F, 8'h7F, 8'h7F, 8'h81);
    send(0, 8'h01, 8'h02, 8'h03, 8'h04);
    wait_lat("lat_abort", 3);
    for (int i = 0; i < 4; i++) send(3, 8'h10, 8'hF0, 8'h08, 8'h04);
    wait_lat("lat_frame2", 3);
    drain();

    // Backpressure: hold the consumer off for five cycles mid-stream.
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(1, 8'(i * 16), 8'(i), 8'h03, 8'(i * 2));
      end
      begin
        int w = 0;
        while (!dout_vld && w < 30) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1 dout_rdy = 1'b0;
        @(negedge clk);
        snap = {dout_re, dout_im, dout_ovf};
        chk("bp_vld", {31'd0, dout_vld}, 32'd1);
        chk("bp_rdy", {31'd0, din_rdy}, 32'd0);
        repeat (4) begin
          @(negedge clk);
          chk("bp_stable", {15'd0, dout_re, dout_im, dout_ovf}, {15'd0, snap});
          chk("bp_rdy", {31'd0, din_rdy}, 32'd0);
        end
        @(posedge clk);
        #1 dout_rdy = 1'b1;
      end
    join
    drain();

    // Reset with three partial-frame beats in flight.
    for (int i = 0; i < 3; i++) send(3, 8'h55, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    rst = 1'b1;
    mre = 0; mim = 0; mcnt = 0;
    @(negedge clk);
    chk("mid_rst_re", {24'd0, dout_re}, 32'd0);
    chk("mid_rst_im", {24'd0, dout_im}, 32'd0);
    chk("mid_rst_vld", {31'd0, dout_vld}, 32'd0);
    chk("mid_rst_ovf", {31'd0, dout_ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rdy", {31'd0, din_rdy}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_vld", {31'd0, dout_vld}, 32'd0);
    end
    for (int i = 0; i < 4; i++) send(3, 8'h20, 8'h00, 8'h40, 8'h00);
    wait_lat("lat_post_rst", 3);
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_alu_pipe.md
COMPLEX_ALU_PIPE -- requirements
Module: complex_alu_pipe

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, meaning signed two's-complement width of every real/imag operand and result (Q1.(D_WIDTH-1)).
REQ-002 SHALL have parameter ACC_LEN, default 16, meaning beats per accumulate frame (power of two, >=2).
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-004 SHALL have cal_mode (in, 2): 0 add, 1 sub, 2 mul, 3 conj-mul-accumulate.
REQ-005 SHALL have din_vld (in, 1) and din_rdy (out, 1): input handshake; beat accepted when both high on a rising edge.
REQ-006 SHALL have din_re_1, din_im_1, din_re_2, din_im_2 (in, D_WIDTH each): operands a=(re_1,im_1), b=(re_2,im_2).
REQ-007 SHALL have dout_re, dout_im (out, D_WIDTH each), dout_vld (out, 1), dout_rdy (in, 1): output handshake.
REQ-008 SHALL have dout_ovf (out, 1): high with dout_vld when either result component saturated.

Function
REQ-009 SHALL sample cal_mode together with operands on each accepted beat, so the mode may change on any beat.
REQ-010 SHALL compute mode 0 as a+b and mode 1 as a-b, per component, saturating to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
REQ-011 SHALL compute mode 2 as a*b: re=re1*re2-im1*im2, im=re1*im2+im1*re2, using full-precision products.
REQ-012 SHALL compute mode 3 as a*conj(b): re=re1*re2+im1*im2, im=im1*re2-re1*im2, summed at full precision over ACC_LEN accepted beats.
REQ-013 SHALL size the accumulator at 2*D_WIDTH+1+log2(ACC_LEN) bits, so no internal overflow is possible.
REQ-014 SHALL scale mode 2/3 results by adding 2^(D_WIDTH-2), arithmetic-shifting right by D_WIDTH-1 (round half up), then saturating.
REQ-015 SHALL be a 3-stage pipeline: input register, product/sum, round/saturate; modes 0-2 give dout_vld 3 enabled cycles after acceptance.
REQ-016 SHALL, in mode 3, produce no output for beats 1..ACC_LEN-1 of a frame and one output 3 enabled cycles after the ACC_LEN-th beat.
REQ-017 SHALL keep a frame beat counter (0..ACC_LEN-1) that wraps to 0 on frame completion, clearing the accumulator for the next frame.
REQ-018 SHALL, when a non-mode-3 beat is accepted during a partial frame, discard the partial accumulation, reset the counter to 0, and process that beat normally.
REQ-019 SHALL preserve output order equal to acceptance order.
REQ-020 SHALL stall all pipeline stages, counter and accumulator while dout_vld=1 and dout_rdy=0; dout_* SHALL hold stable during stall.
REQ-021 SHALL drive din_rdy = !(dout_vld && !dout_rdy); din_vld while din_rdy=0 is not accepted.
REQ-022 SHALL sustain one accepted beat per cycle when dout_rdy is held high.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, clear all pipeline valids, the counter and the accumulator regardless of in-flight beats or partial frames.
REQ-024 SHALL reset dout_re=0, dout_im=0, dout_vld=0, dout_ovf=0; din_rdy=1 in the cycle after reset.
REQ-025 SHALL accept no beat on a cycle where rst=1.

Structure
REQ-026 SHALL place mode encodings (MODE_ADD/SUB/MUL/CMAC) and the saturate/round width helpers in shared package complex_pkg.
REQ-027 SHALL implement round-and-saturate in one sub-module, cplx_rnd_sat, instantiated for re and im.

Verification
REQ-028 SHALL cover mode 0: a=(0x70,0x10), b=(0x20,0x05) -> dout=(0x7F,0x15), dout_ovf=1, latency 3.
REQ-029 SHALL cover mode 2: a=(0x40,0x00), b=(0x40,0x00) -> dout=(0x20,0x00), ovf=0; a=b=(0x80,0x00) -> (0x7F,0x00), ovf=1.
REQ-030 SHALL cover mode 3, ACC_LEN=4: four beats a=(0x20,0x00), b=(0x40,0x00) -> single output (0x40,0x00) 3 cycles after 4th beat, none earlier.
REQ-031 SHALL cover abort: two mode-3 beats then a mode-0 beat -> only the mode-0 result emitted; next four mode-3 beats give a clean frame result.
REQ-032 SHALL cover backpressure: back-to-back mode-1 beats, dout_rdy low 5 cycles -> din_rdy low, dout stable, no loss or reordering.
REQ-033 SHALL cover reset mid-frame with 3 beats in flight -> all outputs zero, no stale dout_vld afterwards.
